// File: rtl/text_write_ctrl.sv
// Write sequencer for the 80x30 text RAM: interprets received bytes as
// printable characters or control codes, tracks the cursor and owns the
// RAM write port so the display side only ever reads.
module text_write_ctrl #(
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 30,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy,
    output logic        byte_drop
);

    localparam int unsigned CELLS = COLS * ROWS;

    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_FF  = 8'h0C;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_ESC = 8'h1B;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ESC_COL = 2'd1,
        ESC_ROW = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [6:0]  esc_col_q, esc_col_d;
    logic [11:0] sweep_q, sweep_d;
    logic        wr_en_q, wr_en_d;
    logic [11:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        busy_q, busy_d;
    logic        byte_drop_q, byte_drop_d;

    logic        col_last;
    logic [4:0]  row_next;
    logic [11:0] cur_addr;
    logic [6:0]  col_clamp;
    logic [4:0]  row_clamp;

    // Cursor arithmetic shared by the decode cases below.
    always_comb begin
        col_last  = (col_q == 7'(COLS - 1));
        row_next  = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
        cur_addr  = 12'(row_q) * 12'(COLS) + 12'(col_q);
        col_clamp = (byte_in > 8'(COLS - 1)) ? 7'(COLS - 1) : byte_in[6:0];
        row_clamp = (byte_in > 8'(ROWS - 1)) ? 5'(ROWS - 1) : byte_in[4:0];
    end

    // Next-state, cursor and write-port decode.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        esc_col_d   = esc_col_q;
        sweep_d     = sweep_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        busy_d      = 1'b0;
        byte_drop_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (byte_valid) begin
                    if (byte_in >= 8'h20 && byte_in <= 8'h7E) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cur_addr;
                        wr_data_d = byte_in;
                        if (col_last) begin
                            col_d = 7'd0;
                            row_d = row_next;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (byte_in)
                            CH_CR: col_d = 7'd0;
                            CH_LF: begin
                                col_d = 7'd0;
                                row_d = row_next;
                            end
                            CH_BS: begin
                                // Erase the cell left of the cursor; column 0 is a no-op.
                                if (col_q != 7'd0) begin
                                    col_d     = col_q - 7'd1;
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = cur_addr - 12'd1;
                                    wr_data_d = CLEAR_CHAR;
                                end
                            end
                            CH_FF: begin
                                // First sweep write is issued right away so busy
                                // and wr_en rise together.
                                state_d   = CLEAR;
                                wr_en_d   = 1'b1;
                                wr_addr_d = 12'd0;
                                wr_data_d = CLEAR_CHAR;
                                sweep_d   = 12'd1;
                                busy_d    = 1'b1;
                            end
                            CH_ESC:  state_d = ESC_COL;
                            default: ;
                        endcase
                    end
                end
            end

            ESC_COL: begin
                if (byte_valid) begin
                    esc_col_d = col_clamp;
                    state_d   = ESC_ROW;
                end
            end

            ESC_ROW: begin
                if (byte_valid) begin
                    col_d   = esc_col_q;
                    row_d   = row_clamp;
                    state_d = IDLE;
                end
            end

            CLEAR: begin
                byte_drop_d = byte_valid;
                if (sweep_q < 12'(CELLS)) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = sweep_q;
                    wr_data_d = CLEAR_CHAR;
                    sweep_d   = sweep_q + 12'd1;
                    busy_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                    sweep_d = 12'd0;
                    col_d   = 7'd0;
                    row_d   = 5'd0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= 7'd0;
            row_q       <= 5'd0;
            esc_col_q   <= 7'd0;
            sweep_q     <= 12'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 12'd0;
            wr_data_q   <= 8'd0;
            busy_q      <= 1'b0;
            byte_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            esc_col_q   <= esc_col_d;
            sweep_q     <= sweep_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            byte_drop_q <= byte_drop_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign busy       = busy_q;
    assign byte_drop  = byte_drop_q;

endmodule

// File: tb/tb_text_write_ctrl.sv
// Directed bench for text_write_ctrl: expected RAM writes are queued as
// stimulus is driven and matched against every wr_en pulse.
module tb_text_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;
    logic        byte_drop;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    logic [19:0] exp_q[$];

    text_write_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy),
        .byte_drop  (byte_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Every write the DUT issues must match the oldest queued expectation.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                check("write_addr", 32'(wr_addr), 32'(e[19:8]));
                check("write_data", 32'(wr_data), 32'(e[7:0]));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic expect_wr(input int addr, input logic [7:0] data);
        exp_q.push_back({12'(addr), data});
    endtask

    task automatic check_cursor(input string tag, input int col, input int row);
        check({tag, "_col"}, 32'(cursor_col), 32'(col));
        check({tag, "_row"}, 32'(cursor_row), 32'(row));
    endtask

    initial begin
        int n;
        int base;
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(byte_drop), 32'd0);
        check_cursor("rst", 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back printable bytes.
        expect_wr(0, 8'h48);
        expect_wr(1, 8'h69);
        byte_valid = 1'b1; byte_in = 8'h48;
        @(negedge clk);
        check_cursor("h", 1, 0);
        byte_in = 8'h69;
        @(negedge clk);
        byte_valid = 1'b0;
        check_cursor("hi", 2, 0);

        // Last cell and wrap to origin.
        send(8'h1B); send(8'h4F); send(8'h1D);
        check_cursor("esc_79_29", 79, 29);
        expect_wr(2399, 8'h41);
        send(8'h41);
        check_cursor("wrap", 0, 0);
        send(8'h1B); send(8'd200); send(8'd99);
        check_cursor("clamp", 79, 29);

        // Backspace.
        send(8'h1B); send(8'd5); send(8'd3);
        expect_wr(245, 8'h78);
        send(8'h78);
        check_cursor("x", 6, 3);
        expect_wr(245, 8'h20);
        send(8'h08);
        check_cursor("bs", 5, 3);
        send(8'h1B); send(8'd0); send(8'd3);
        send(8'h08);
        check_cursor("bs_col0", 0, 3);

        // CR, LF wrap, ignored byte, raw escape bytes.
        send(8'h1B); send(8'd10); send(8'd2);
        send(8'h0D);
        check_cursor("cr", 0, 2);
        send(8'h1B); send(8'd4); send(8'd29);
        send(8'h0A);
        check_cursor("lf_wrap", 0, 0);
        send(8'h1B); send(8'd7); send(8'd9);
        send(8'h07);
        check_cursor("ignore", 7, 9);
        send(8'h1B); send(8'h0C); send(8'h0A);
        check_cursor("esc_raw", 12, 10);
        check("esc_raw_busy", 32'(busy), 32'd0);

        // Clear-screen sweep with a dropped byte mid-way.
        for (int a = 0; a < 2400; a++) expect_wr(a, 8'h20);
        base = wr_count;
        send(8'h0C);
        check("ff_busy", 32'(busy), 32'd1);
        check("ff_first_wr", 32'(wr_en), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            if (n == 500) begin
                byte_valid = 1'b1; byte_in = 8'h41;
                @(negedge clk);
                byte_valid = 1'b0;
                check("byte_drop", 32'(byte_drop), 32'd1);
            end else begin
                @(negedge clk);
            end
            n++;
        end
        check("clear_done_busy", 32'(busy), 32'd0);
        check("clear_wr_count", 32'(wr_count - base), 32'd2400);
        check("clear_queue_empty", 32'(exp_q.size()), 32'd0);
        check_cursor("clear_end", 0, 0);

        // Reset mid-sweep.
        for (int a = 0; a < 2400; a++) expect_wr(a, 8'h20);
        send(8'h0C);
        repeat (1000) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check_cursor("midrst", 0, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_wr(0, 8'h5A);
        send(8'h5A);
        check_cursor("after_rst", 1, 0);
        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_write_ctrl.md
Name: text_write_ctrl

Overview:
- Command-interpreting write sequencer for the 80x30 dual-port text RAM that feeds the glyph pipeline.
- Accepts one byte per strobe from the SPI receive edge detector.
- Decodes control codes (cursor moves, clear screen, escape-positioning) and tracks the cursor.
- Drives the RAM write port (address, data, write enable) so the display side only ever reads.

Parameters:
COLS, 80, characters per row
ROWS, 30, rows per screen
CLEAR_CHAR, 8'h20, fill byte written by clear-screen and backspace

Ports:
clk  in  1  system/pixel clock
rst  in  1  asynchronous, active-high reset
byte_valid  in  1  one-cycle strobe: byte_in holds a new received byte
byte_in  in  8  received byte
wr_en  out  1  text RAM write enable, one cycle per write
wr_addr  out  12  text RAM write address, row*COLS+col
wr_data  out  8  text RAM write data
cursor_col  out  7  current cursor column, 0..COLS-1
cursor_row  out  5  current cursor row, 0..ROWS-1
busy  out  1  high while a clear-screen sweep is in progress
byte_drop  out  1  one-cycle pulse: byte_valid arrived while busy and was discarded

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, cursor (0,0).
- All outputs are registered. A write appears exactly 1 cycle after the accepting byte_valid cycle.
- wr_addr is computed from the pre-update cursor: col + row*80, 12-bit, max 2399.

States:
- IDLE, ESC_COL, ESC_ROW, CLEAR.

IDLE, on byte_valid:
- 0x20..0x7E (printable):
  - wr_en=1, wr_data=byte, wr_addr=cursor.
  - Advance cursor: col+1. If col==COLS-1, then col=0 and row+1. If row==ROWS-1, row wraps to 0 (no scroll).
- 0x0D (CR): col=0, no write.
- 0x0A (LF): col=0, row+1 with wrap as above, no write.
- 0x08 (BS):
  - If col>0: col-1, then write CLEAR_CHAR at the new position.
  - If col==0: no change, no write.
- 0x0C (FF): go to CLEAR with sweep address 0, busy=1 on the next cycle.
- 0x1B (ESC): go to ESC_COL.
- Any other byte: ignored, no state change.

ESC_COL, on byte_valid:
- Latch col = min(byte, COLS-1), then go to ESC_ROW. No write.

ESC_ROW, on byte_valid:
- row = min(byte, ROWS-1), col = the latched value, cursor applied this cycle; return to IDLE. No write.
- Escape bytes are taken raw; control-code meanings do not apply.

CLEAR:
- One write per cycle: wr_en=1, wr_data=CLEAR_CHAR, wr_addr = 0,1,...,COLS*ROWS-1.
- Exactly 2400 consecutive wr_en cycles.
- On the cycle after the last write (addr 2399): busy=0, cursor (0,0), return to IDLE.
- busy is high from the cycle of the first clear write through the last.
- byte_valid while busy: byte discarded, byte_drop pulses 1 cycle later, sweep unaffected.

Boundary conditions:
- byte_valid outside IDLE/ESC states is only possible in CLEAR; it is dropped as above.
- Back-to-back byte_valid in consecutive cycles must each be processed (full throughput in IDLE/ESC).
- Cursor outputs always reflect post-update state, in the same cycle as the corresponding wr_en.
- rst asserted mid-CLEAR or mid-escape: immediate return to IDLE, cursor (0,0), wr_en=0, busy=0. Partially cleared RAM is left as is.
- Address arithmetic never exceeds 2399. Cursor values are always in range, including after clamping.

Test Plan:
- Reset, then bytes 'H'(0x48),'i'(0x69) -> wr_en pulses with addr 0 data 0x48, then addr 1 data 0x69; cursor ends (2,0).
- ESC,0x4F,0x1D (col 79, row 29), then 'A' -> write addr 2399 data 0x41; cursor wraps to (0,0). ESC,200,99 -> cursor clamped to (79,29).
- ESC,5,3, then 'x', then BS -> write addr 245 data 0x78, then write addr 245 data 0x20; cursor (5,3). BS at col 0 -> no wr_en.
- 0x0C -> busy high; 2400 consecutive wr_en with addr 0..2399 and data 0x20; then busy low, cursor (0,0). A byte injected mid-sweep gives a byte_drop pulse and no extra write.
- ESC,10,2, then CR -> cursor (0,2); LF at row 29 -> cursor (0,0). Byte 0x07 -> no write, cursor unchanged.
- Assert rst at sweep address ~1000 -> outputs zero immediately; after release, 'Z' writes addr 0.
